// File: rtl/branch_predictor.sv
// Fetch-side direct-mapped BTB with 2-bit saturating direction counters.
// Combinational lookup and mispredict resolution; table training and perf counters on the rising edge.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  input  logic        stats_clr,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int TAG_W = 30 - IDX_W;

  function automatic logic [1:0] ctr_up(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dn(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (&c) ? c : c + 32'd1;
  endfunction

  logic             vld_q [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [31:0]      tgt_q [ENTRIES];
  logic [1:0]       ctr_q [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             if_hit;
  logic             upd_hit;
  logic             unused_pc_lsbs;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Instruction-alignment bits never reach the table.
  assign unused_pc_lsbs = ^{if_pc[1:0]};

  // Lookup stage: reads pre-update state, no write bypass.
  assign if_hit      = vld_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : 32'd0;

  // Resolution stage.
  assign upd_hit     = vld_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  // Table training lands at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= 32'd0;
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_q[upd_idx] <= ctr_up(ctr_q[upd_idx]);
          tgt_q[upd_idx] <= upd_target;
        end else begin
          ctr_q[upd_idx] <= ctr_dn(ctr_q[upd_idx]);
        end
      end else if (upd_taken) begin
        // Taken miss evicts whatever alias held the slot; not-taken misses never allocate.
        vld_q[upd_idx] <= 1'b1;
        tag_q[upd_idx] <= upd_tag;
        tgt_q[upd_idx] <= upd_target;
        ctr_q[upd_idx] <= 2'b10;
      end
    end
  end

  // Performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else if (stats_clr) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      if (upd_valid)  branch_cnt  <= sat_inc(branch_cnt);
      if (mispredict) mispred_cnt <= sat_inc(mispred_cnt);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk;
  logic        reset_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        stats_clr;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .stats_clr(stats_clr),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: one record per slot, plain integers.
  bit          m_vld [ENTRIES];
  int unsigned m_tag [ENTRIES];
  int unsigned m_tgt [ENTRIES];
  int          m_ctr [ENTRIES];
  longint unsigned m_br;
  longint unsigned m_mp;

  function automatic int unsigned slot_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int unsigned s = slot_of(pc);
    return m_vld[s] && (m_tag[s] == tag_of(pc));
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return model_hit(pc) && (m_ctr[slot_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    return model_pred(pc) ? m_tgt[slot_of(pc)] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  function automatic bit model_misp();
    return upd_valid && ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
  endfunction

  task automatic model_edge();
    int unsigned s;
    bit mp;
    mp = model_misp();
    if (upd_valid) begin
      s = slot_of(upd_pc);
      if (model_hit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = upd_target;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_vld[s] = 1; m_tag[s] = tag_of(upd_pc); m_tgt[s] = upd_target; m_ctr[s] = 2;
      end
    end
    if (stats_clr) begin
      m_br = 0; m_mp = 0;
    end else begin
      if (upd_valid && m_br < 64'hFFFF_FFFF) m_br++;
      if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
    end
  endtask

  // Drive one cycle of inputs (called away from the edge) and check combinational outputs.
  task automatic apply(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt, input logic clr, input logic [31:0] ipc);
    upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt; stats_clr = clr; if_pc = ipc;
    #1;
    check("pred_taken", {31'd0, pred_taken}, {31'd0, model_pred(ipc)});
    check("pred_target", pred_target, model_target(ipc));
    check("mispredict", {31'd0, mispredict}, {31'd0, model_misp()});
    check("redirect_pc", redirect_pc, t ? tgt : pc + 32'd4);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("branch_cnt", branch_cnt, m_br[31:0]);
    check("mispred_cnt", mispred_cnt, m_mp[31:0]);
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] ipc);
    apply(0, 32'd0, 0, 32'd0, 0, 32'd0, 0, ipc);
    tick();
  endtask

  logic [31:0] pc_pool [8];
  logic [31:0] tgt_pool [4];

  initial begin
    logic [31:0] rpc, rtgt, ripc, rptgt;
    logic        rt, rpt, rclr;

    pc_pool = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h200, 32'h1004, 32'h2100, 32'h13C};
    tgt_pool = '{32'h80, 32'h90, 32'h300, 32'h4000};

    reset_n = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    upd_pred_taken = 0; upd_pred_target = 0; stats_clr = 0; if_pc = 32'h100;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Reset state.
    apply(0, 32'd0, 0, 32'd0, 0, 32'd0, 0, 32'h100);
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_pred_target", pred_target, 32'd0);
    tick();
    check("rst_branch_cnt", branch_cnt, 32'd0);

    // First taken branch allocates; lookup in the same cycle still misses.
    apply(1, 32'h100, 1, 32'h80, 0, 32'h0, 0, 32'h100);
    check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    check("alloc_redirect", redirect_pc, 32'h80);
    tick();
    check("alloc_mispred_cnt", mispred_cnt, 32'd1);
    apply(0, 32'd0, 0, 32'd0, 0, 32'd0, 0, 32'h100);
    check("alloc_hit_taken", {31'd0, pred_taken}, 32'd1);
    check("alloc_hit_target", pred_target, 32'h80);
    tick();

    // Train down to strong-NT, then back up to weak-T.
    apply(1, 32'h100, 0, 32'h80, 1, 32'h80, 0, 32'h100); tick();
    apply(1, 32'h100, 0, 32'h80, 0, 32'h0, 0, 32'h100); tick();
    apply(1, 32'h100, 0, 32'h80, 0, 32'h0, 0, 32'h100); tick();
    apply(1, 32'h100, 1, 32'h80, 0, 32'h0, 0, 32'h100); tick();
    apply(1, 32'h100, 1, 32'h80, 0, 32'h0, 0, 32'h100); tick();
    idle(32'h100);

    // Not-taken miss at an alias: no allocation, fall-through redirect.
    apply(1, 32'h200, 0, 32'h500, 0, 32'h0, 0, 32'h100);
    check("nt_mispredict", {31'd0, mispredict}, 32'd0);
    check("nt_redirect", redirect_pc, 32'h204);
    tick();
    idle(32'h200);
    idle(32'h100);

    // Taken alias evicts 0x100.
    apply(1, 32'h140, 1, 32'h80, 0, 32'h0, 0, 32'h100); tick();
    idle(32'h100);
    idle(32'h140);
    // Right direction, wrong target.
    apply(1, 32'h140, 1, 32'h90, 1, 32'h80, 0, 32'h140);
    check("wrong_tgt_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    idle(32'h140);

    // Randomized traffic over a small set of aliasing PCs.
    for (int n = 0; n < 400; n++) begin
      rpc  = pc_pool[$urandom_range(0, 7)];
      ripc = pc_pool[$urandom_range(0, 7)];
      rt   = 1'($urandom_range(0, 1));
      rtgt = tgt_pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) begin
        rpt   = model_pred(rpc);
        rptgt = model_target(rpc);
      end else begin
        rpt   = 1'($urandom_range(0, 1));
        rptgt = tgt_pool[$urandom_range(0, 3)];
      end
      rclr = ($urandom_range(0, 39) == 0);
      apply(($urandom_range(0, 3) != 0), rpc, rt, rtgt, rpt, rptgt, rclr, ripc);
      tick();
    end

    // Counter saturation from a preloaded value.
    force dut.branch_cnt  = 32'hFFFF_FFFE;
    force dut.mispred_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt;
    release dut.mispred_cnt;
    m_br = 64'hFFFF_FFFE;
    m_mp = 64'hFFFF_FFFE;
    repeat (3) begin
      apply(1, 32'h180, 1, 32'h4000, 0, 32'h0, 0, 32'h180);
      tick();
    end
    check("sat_branch_cnt", branch_cnt, 32'hFFFF_FFFF);
    check("sat_mispred_cnt", mispred_cnt, 32'hFFFF_FFFF);
    apply(1, 32'h180, 1, 32'h4000, 0, 32'h0, 1, 32'h180);
    tick();
    check("clr_branch_cnt", branch_cnt, 32'd0);
    check("clr_mispred_cnt", mispred_cnt, 32'd0);

    // Reset asserted mid-update discards the update and clears everything.
    apply(1, 32'h140, 1, 32'h300, 0, 32'h0, 0, 32'h180);
    tick();
    apply(1, 32'h1004, 1, 32'h300, 0, 32'h0, 0, 32'h180);
    reset_n = 0;
    #1;
    model_reset();
    check("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("midrst_branch_cnt", branch_cnt, 32'd0);
    check("midrst_mispred_cnt", mispred_cnt, 32'd0);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 0;
    reset_n = 1;
    idle(32'h180);
    idle(32'h1004);
    idle(32'h140);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor for the 5-stage RV32I pipeline. Each cycle it looks up the IF-stage PC in a direct-mapped branch target buffer with 2-bit saturating counters and returns a taken/not-taken prediction and a target. When the ID-stage branch comparator resolves a conditional branch, the block trains the table, flags a misprediction, and supplies the corrected PC. Two performance counters track resolved branches and mispredictions.

## Interface
Parameters:
- ENTRIES, 16: BTB/BHT entries; power of two, 4..256.
- IDX_W, $clog2(ENTRIES): index width; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- reset_n  input  1  Asynchronous, active-low reset.
- if_pc  input  32  Current fetch PC.
- pred_taken  output  1  Predict taken for if_pc (combinational).
- pred_target  output  32  Predicted target; 0 when pred_taken=0.
- upd_valid  input  1  ID stage holds a resolved conditional branch (opcode 1100011) this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  Branch outcome from the branch comparator.
- upd_target  input  32  Computed branch target (pc + imm).
- upd_pred_taken  input  1  Prediction issued for this branch, carried down the pipeline.
- upd_pred_target  input  32  Predicted target carried down the pipeline.
- mispredict  output  1  Prediction was wrong; front end must flush and redirect.
- redirect_pc  output  32  Correct next PC: upd_target if upd_taken, else upd_pc+4.
- stats_clr  input  1  Synchronous clear of both performance counters.
- branch_cnt  output  32  Resolved branches since reset/clear.
- mispred_cnt  output  32  Mispredictions since reset/clear.

## Operation
- Entry state: valid (1b), tag, target (32b), ctr (2b). Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup: hit = valid[idx] && tag match. pred_taken = hit && ctr[1]. pred_target = target[idx] when pred_taken, else 0.
- Update, only when upd_valid=1, with idx/tag from upd_pc:
  - Hit, taken: ctr saturating +1 (11 stays 11). Target rewritten with upd_target.
  - Hit, not taken: ctr saturating -1 (00 stays 00). Target unchanged.
  - Miss, taken: allocate and replace any existing entry. valid=1, tag, target=upd_target, ctr=10.
  - Miss, not taken: no table change.
- mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)). It is 0 whenever upd_valid=0.
- redirect_pc is always driven per the rule above; the consumer qualifies it with mispredict.
- Counters: branch_cnt +1 per upd_valid cycle; mispred_cnt +1 per mispredict cycle. Both saturate at 0xFFFF_FFFF. stats_clr takes priority over a same-cycle increment, leaving the counter at 0.
- upd_pc[1:0] and if_pc[1:0] are ignored.

## Timing
- Reset (reset_n=0, asynchronous): all valid=0, all ctr=01, targets/tags=0, branch_cnt=mispred_cnt=0. As a result, pred_taken=0, pred_target=0, and mispredict=0 unless upd_valid is asserted.
- Lookup and mispredict/redirect_pc are combinational, with 0-cycle latency. The counters are registered.
- Table writes land at the rising edge. An update is visible to lookup starting the next cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update state. There is no bypass.
- A reset asserted mid-operation discards any pending update that cycle. Table and counters return to their reset values immediately.
- Aliasing: PCs that share an index but differ in tag replace each other on a taken-miss allocation. A not-taken alias never evicts.

## Test plan
- Reset, then if_pc=0x100 for any cycle -> pred_taken=0, pred_target=0, branch_cnt=0, mispred_cnt=0.
- Update pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80, mispred_cnt=1. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Three not-taken updates on 0x100 after allocation (ctr 10->01->00->00) -> pred_taken=0 after the first. Next, one taken -> ctr=01, still not taken. Second taken -> predicts taken.
- Update pc=0x200, not taken, pred_taken=0 -> mispredict=0, redirect_pc=0x204, no allocation, branch_cnt increments, mispred_cnt unchanged.
- Aliasing with ENTRIES=16: allocate 0x100, then taken update at 0x140 -> lookup 0x100 now misses and 0x140 hits. Correct-direction prediction with wrong target (pred_target=0x80, upd_target=0x90) -> mispredict=1.
- Counter saturation: preload via 2^32 updates (or force) -> stays 0xFFFF_FFFF. stats_clr together with upd_valid -> counter=0. Assert reset_n low mid-update -> everything returns to reset values.
